// File: rtl/hb_pkg.sv
// Shared mode codes, controller state type and switch-to-mode decode
// for the heartbeat LED mode controller.
package hb_pkg;

    localparam logic [3:0] MODE_1   = 4'd1;
    localparam logic [3:0] MODE_2   = 4'd2;
    localparam logic [3:0] MODE_3   = 4'd3;
    localparam logic [3:0] MODE_4   = 4'd4;
    localparam logic [3:0] MODE_OFF = 4'hF;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    // Exactly one switch set selects a mode; anything else is off/fault.
    function automatic logic [3:0] decode_mode(input logic [3:0] sw);
        logic [3:0] mode;
        case (sw)
            4'b0001: mode = MODE_1;
            4'b0010: mode = MODE_2;
            4'b0100: mode = MODE_3;
            4'b1000: mode = MODE_4;
            default: mode = MODE_OFF;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/hb_debounce.sv
// Two-flop synchroniser plus consecutive-sample debouncer for the DIP bank.
// sw_stable only follows a value that has held for DEB_CYCLES samples.
module hb_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] sw_i,
    output logic [3:0] sw_stable
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [3:0]       sw_meta;
    logic [3:0]       sw_s;
    logic [3:0]       sw_cand;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_meta   <= '0;
            sw_s      <= '0;
            sw_cand   <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else begin
            sw_meta <= sw_i;
            sw_s    <= sw_meta;
            if (sw_s != sw_cand) begin
                sw_cand <= sw_s;
                cnt     <= '0;
            end else begin
                // Counter saturates at the accept point; sw_stable keeps refreshing.
                if (cnt != CNT_LAST) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    sw_stable <= sw_cand;
                end
            end
        end
    end

endmodule

// File: rtl/hb_mode_ctrl.sv
// Heartbeat LED mode controller: debounced DIP decode, then every mode change
// is sequenced fade-out -> swap (at level 0) -> fade-in.
module hb_mode_ctrl
    import hb_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned RAMP_DIV   = 50000,
    parameter int unsigned LVL_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       sw_i,
    output logic [3:0]       mode_o,
    output logic [LVL_W-1:0] level_o,
    output logic             mode_strobe_o,
    output logic             busy_o,
    output logic             fault_o
);

    localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = '1;

    logic [3:0]       sw_stable;
    logic [3:0]       target;
    logic             tick;
    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic [LVL_W-1:0] level_d;
    logic [3:0]       mode_d;
    logic             strobe_d;

    hb_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sw_i     (sw_i),
        .sw_stable(sw_stable)
    );

    assign target = decode_mode(sw_stable);
    assign tick   = (presc_q == PRE_LAST);
    assign busy_o = (state_q != RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (target != mode_o) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                // A reverted switch resumes fading in without touching the mode.
                if (target == mode_o && mode_o != MODE_OFF) state_d = FADE_IN;
                else if (level_o == '0)                      state_d = SWAP;
            end
            SWAP: begin
                state_d = (target != MODE_OFF) ? FADE_IN : RUN;
            end
            FADE_IN: begin
                if (target != mode_o)        state_d = FADE_OUT;
                else if (level_o == LVL_MAX) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        level_d  = level_o;
        mode_d   = mode_o;
        strobe_d = 1'b0;
        case (state_q)
            FADE_OUT: if (tick && level_o != '0)     level_d = level_o - 1'b1;
            FADE_IN:  if (tick && level_o != LVL_MAX) level_d = level_o + 1'b1;
            SWAP: begin
                mode_d   = target;
                strobe_d = 1'b1;
            end
            default: ;
        endcase
        // Every state change restarts the ramp period from zero.
        if (state_d != state_q || tick) presc_d = '0;
        else                            presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q       <= '0;
            level_o       <= '0;
            mode_o        <= MODE_OFF;
            mode_strobe_o <= 1'b0;
            fault_o       <= 1'b1;
        end else begin
            presc_q       <= presc_d;
            level_o       <= level_d;
            mode_o        <= mode_d;
            mode_strobe_o <= strobe_d;
            fault_o       <= (mode_d == MODE_OFF);
        end
    end

endmodule
